multiplier: RTL and testbench

//   Sequential shift-add multiplier; the inverse datapath of the restoring divider.

---
 rtl/multiplier_if.sv | 22 ++
 rtl/multiplier.sv | 100 ++++++++++
 tb/tb_multiplier.sv | 132 +++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// Start/busy/done handshake bundle between the execute-stage control and the multiplier.
interface multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 inp_start;
  logic                 inp_signed;
  logic [WIDTH-1:0]     inp_a;
  logic [WIDTH-1:0]     inp_b;
  logic                 out_busy;
  logic                 out_done;
  logic [2*WIDTH-1:0]   out_result;

  modport master (
    output inp_start, inp_signed, inp_a, inp_b,
    input  out_busy, out_done, out_result
  );

  modport slave (
    input  inp_start, inp_signed, inp_a, inp_b,
    output out_busy, out_done, out_result
  );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add multiplier: magnitudes are multiplied, and the sign is applied at the end.
//   state  | meaning
//   S_IDLE | waiting for inp_start; latches magnitudes and result sign
//   S_RUN  | one add/shift iteration per cycle, WIDTH cycles
//   S_FIX  | negate accumulator when the result sign is negative
//   S_DONE | publish product; out_done pulses in the following cycle
module multiplier #(
  parameter int WIDTH = 16
) (
  input  logic         inp_clk,
  input  logic         inp_rst_n,
  multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_a = (bus.inp_signed && bus.inp_a[WIDTH-1]) ? (~bus.inp_a) + WIDTH'(1) : bus.inp_a;
  assign mag_b = (bus.inp_signed && bus.inp_b[WIDTH-1]) ? (~bus.inp_b) + WIDTH'(1) : bus.inp_b;

  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.inp_start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = bus.inp_signed & (bus.inp_a[WIDTH-1] ^ bus.inp_b[WIDTH-1]);
          acc_d    = '0;
          count_d  = CW'(WIDTH);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        acc_d   = neg_q ? (~acc_q) + (2*WIDTH)'(1) : acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.out_busy   = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.out_done   = done_q;
  assign bus.out_result = result_q;
endmodule

// File: tb/tb_multiplier.sv
// Directed and random checks of the shift-add multiplier against an integer-arithmetic reference.
module tb_multiplier;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_if #(.WIDTH(W)) bus ();
  multiplier #(.WIDTH(W)) dut (.inp_clk(clk), .inp_rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  logic [2*W-1:0] last_res = '0;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(sa * sb);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a one-cycle start; returns just after the accepting edge, with operands scrambled.
  task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic s);
    @(negedge clk);
    bus.inp_a = a; bus.inp_b = b; bus.inp_signed = s; bus.inp_start = 1'b1;
    @(posedge clk);
    #1;
    bus.inp_start = 1'b0;
    bus.inp_a = W'($urandom); bus.inp_b = W'($urandom); bus.inp_signed = 1'($urandom);
  endtask

  task automatic wait_done(string tag, logic [2*W-1:0] exp);
    int  lat;
    logic busy_ok, held_ok;
    lat = -1; busy_ok = 1'b1; held_ok = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (bus.out_done === 1'b1) begin lat = j; break; end
      if (bus.out_busy !== ((j <= W) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (bus.out_result !== last_res) held_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, W + 2);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_held"}, held_ok, 1'b1);
    check({tag, "_result"}, bus.out_result, exp);
    last_res = exp;
    @(negedge clk);
    check({tag, "_pulse"}, bus.out_done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    int   gap, ndone;
    bus.inp_start = 1'b0; bus.inp_signed = 1'b0; bus.inp_a = '0; bus.inp_b = '0;
    #1;
    check("rst_busy", bus.out_busy, 1'b0);
    check("rst_done", bus.out_done, 1'b0);
    check("rst_result", bus.out_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    start_op(16'd3, 16'd5, 1'b0);          wait_done("u_small", 32'h0000_000F);
    start_op(16'hFFFF, 16'hFFFF, 1'b0);    wait_done("u_max", 32'hFFFE_0001);
    start_op(16'hFFFD, 16'd5, 1'b1);       wait_done("s_mixed", 32'hFFFF_FFF1);
    start_op(16'h8000, 16'h8000, 1'b1);    wait_done("s_minsq", 32'h4000_0000);
    start_op(16'h8000, 16'h0001, 1'b1);    wait_done("s_minx1", 32'hFFFF_8000);
    start_op(16'h0000, 16'hFFFF, 1'b1);    wait_done("s_zero", 32'h0000_0000);

    // Start while busy, then start held high across completion.
    start_op(16'd7, 16'd9, 1'b0);
    gap = -1;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j == 5) begin bus.inp_a = 16'd2; bus.inp_b = 16'd2; bus.inp_start = 1'b1; end
      if (j == 6) bus.inp_start = 1'b0;
      if (j == 10) begin bus.inp_a = 16'd7; bus.inp_b = 16'd9; bus.inp_signed = 1'b0; bus.inp_start = 1'b1; end
      if (j <= W && bus.out_busy !== 1'b1) check("busy_hold", bus.out_busy, 1'b1);
      if (bus.out_done === 1'b1) begin gap = j; break; end
    end
    check("busy_start_lat", gap, W + 2);
    check("busy_start_res", bus.out_result, 63);
    gap = -1;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      if (bus.out_done === 1'b1) begin gap = m; break; end
    end
    bus.inp_start = 1'b0;
    check("b2b_period", gap, W + 3);
    check("b2b_result", bus.out_result, 63);
    last_res = 63;
    repeat (2) @(negedge clk);
    check("b2b_stop", bus.out_busy, 1'b0);

    // Asynchronous reset in the middle of an operation.
    start_op(16'd100, 16'd100, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.out_busy, 1'b0);
    check("mid_rst_result", bus.out_result, 0);
    check("mid_rst_done", bus.out_done, 1'b0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_done === 1'b1) ndone++;
    end
    check("mid_rst_nodone", ndone, 0);
    check("mid_rst_idle", bus.out_busy, 1'b0);
    last_res = '0;
    start_op(16'd100, 16'd100, 1'b0);      wait_done("post_rst", 32'h0000_2710);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (i == 0) ra = 16'h8000;
      if (i == 1) rb = 16'h7FFF;
      start_op(ra, rb, rs);
      wait_done($sformatf("rand%0d", i), ref_mul(ra, rb, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
